fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//   Shares the single write port of the 16-bit synchronous FIFO between NUM_REQ producers.
//   - Round-robin arbitration with bounded bursts.
//   - Per-requester valid/ready handshake.
//   - Drives wr_en/data_in with one registered stage.
//   - Throttles on full/almostfull so the FIFO never overflows.
//   - Watches wr_ack/overflow and reports protocol errors.
//   Sits between the producer blocks and the FIFO DUT modport.
// PARAMETERS
//   FIFO_WIDTH  16  data width of each requester and of the FIFO write port
//   NUM_REQ     4   number of requesters, >=2
//   BURST_MAX   4   max beats accepted per grant before forced re-arbitration, >=1
// PORTS
//   clk          in   1                   the single clock; everything is on its rising edge
//   rst_n        in   1                   synchronous, active-low reset
//   req_valid    in   NUM_REQ             requester i has a beat
//   req_data     in   NUM_REQ*FIFO_WIDTH  beat of requester i at [i*W +: W]
//   req_ready    out  NUM_REQ             beat of requester i accepted this cycle
//   wr_en        out  1                   FIFO write strobe, registered
//   data_in      out  FIFO_WIDTH          FIFO write data, registered
//   full         in   1                   FIFO full
//   almostfull   in   1                   FIFO has exactly one free slot
//   wr_ack       in   1                   FIFO acknowledged the write of the previous cycle
//   overflow     in   1                   FIFO rejected a write
//   grant_valid  out  1                   a burst owner exists (state BURST)
//   grant_id     out  $clog2(NUM_REQ)     current owner
//   ovf_cnt      out  8                   saturating count of overflow pulses
//   ack_err      out  1                   sticky: wr_ack missing, or present without a write
// BEHAVIOUR
//   Reset (rst_n==0 at posedge):
//   - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
//   - wr_en=0, data_in=0, ovf_cnt=0, ack_err=0.
//   - Any in-flight beat is discarded. req_ready is 0 while rst_n is low.
//   FSM IDLE:
//   - If any req_valid, the winner is the first set bit scanning from rr_ptr upward, with wrap.
//   - owner<=winner, burst_cnt<=0, go to BURST. This costs one arbitration cycle with no accept.
//   - Otherwise stay in IDLE.
//   FSM BURST:
//   - can_wr = !full && !(almostfull && wr_en). The term with the pending registered write
//     covers flag lag.
//   - req_ready[owner] = req_valid[owner] && can_wr (combinational). All other req_ready are 0.
//   - Accept when req_valid[owner] && req_ready[owner]:
//     - Next cycle wr_en=1 and data_in=req_data[owner]. Otherwise wr_en=0 and data_in holds.
//     - burst_cnt++.
//   - Leave BURST for IDLE, with rr_ptr<=owner+1 mod NUM_REQ, when either:
//     - a beat is accepted while burst_cnt==BURST_MAX-1, or
//     - req_valid[owner]==0.
//   - While !can_wr the owner keeps the grant (stall); burst_cnt does not advance.
//   Outputs: grant_valid = (state==BURST), grant_id = owner.
//   Ordering and latency:
//   - Beats from a single requester reach the FIFO in acceptance order.
//   - Latency from accept to wr_en is exactly 1 cycle.
//   Fairness: a sole requester re-wins after one idle cycle per BURST_MAX beats.
//   Monitoring:
//   - ovf_cnt increments on each overflow cycle and saturates at 255.
//   - ack_err is set if wr_ack != wr_en delayed by one cycle. It clears only on reset.
//   Simultaneous events:
//   - A burst end and a new request in the same cycle are handled by the IDLE cycle.
//   - full asserting in the same cycle as an accept is impossible by the can_wr rule.
// STRUCTURE
//   fifo_arb_pkg:
//   - arb_state_e {IDLE, BURST}
//   - localparam ID_W = $clog2(NUM_REQ)
//   - function rr_next(ptr) for the wrap increment.
//   Sub-module rr_picker (combinational):
//   - Inputs: req vector, start pointer.
//   - Outputs: winner index, any flag.
//   - Method: rotate, priority-encode, un-rotate.
//   Top: FSM, burst counter, output register, monitors.
// TESTING
//   1. Reset: hold rst_n=0 for 3 cycles with all req_valid=1
//      -> wr_en=0, req_ready=0, ovf_cnt=0, ack_err=0, grant_valid=0.
//   2. RR bursts: req_valid=4'b1111 and an empty FIFO (FIFO_DEPTH=8)
//      -> grants 0,1,2,3 in turn, 4 beats each.
//      -> After 2 bursts the FIFO is full and req_ready stays 0 until a read frees a slot.
//      -> data order is preserved per requester.
//   3. Flag lag: FIFO at 7/8 with writes back-to-back
//      -> exactly one more beat accepted. overflow is never seen and ovf_cnt stays 0.
//   4. Early drop: requester 2 drops valid after 2 beats
//      -> IDLE, then requester 3 granted. rr_ptr=3.
//   5. Sole requester 1 for 10 beats -> accepts 4,4,2 with one-cycle gaps between bursts.
//   6. Error injection:
//      - Force wr_ack=0 after a write -> ack_err=1 and stays set.
//      - Pulse overflow 300 times -> ovf_cnt=255.
//      - Reset mid-burst -> all outputs return to reset values.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and round-robin pointer arithmetic for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int ID_W        = $clog2(DEF_NUM_REQ);

  // (base + inc) mod n for base, inc < n, without a divider
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned inc,
                                          input int unsigned n);
    int unsigned s;
    s = base + inc;
    if (s >= n) s = s - n;
    return s;
  endfunction

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return rr_wrap(ptr, 1, n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after start_i, with wrap.
// Zero latency; any_o low means winner_o is don't-care.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = ID_W
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] winner_o,
  output logic          any_o
);

  logic [N-1:0] rot;
  int unsigned  off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req_i[IW'(rr_wrap(32'(start_i), i, N))];
    end
    // descending scan leaves the lowest set bit of the rotated vector
    off = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    winner_o = IW'(rr_wrap(32'(start_i), off, N));
    any_o    = |req_i;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded sharing of one FIFO write port; one registered stage to wr_en/data_in.
// Backpressure: req_ready drops whenever the FIFO is full or its last slot is already claimed.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int BURST_MAX  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            wr_en,
  output logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            full,
  input  logic                            almostfull,
  input  logic                            wr_ack,
  input  logic                            overflow,
  output logic                            grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic [7:0]                      ovf_cnt,
  output logic                            ack_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(BURST_MAX + 1);

  arb_state_e            state_q, state_d;
  logic [IDW-1:0]        owner_q, owner_d, rr_ptr_q, rr_ptr_d, winner;
  logic [BCW-1:0]        burst_cnt_q, burst_cnt_d;
  logic                  wr_en_q, wr_en_d, wr_en_dly_q;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [7:0]            ovf_cnt_q;
  logic                  ack_err_q;
  logic                  any_req, can_wr, own_vld, accept, last_beat;
  logic [FIFO_WIDTH-1:0] req_beat [NUM_REQ];

  rr_picker #(.N(NUM_REQ), .IW(IDW)) u_pick (
    .req_i    (req_valid),
    .start_i  (rr_ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_beat[i] = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  // a pending registered write may consume the last slot before almostfull/full catch up
  assign can_wr    = !full && !(almostfull && wr_en_q);
  assign own_vld   = req_valid[owner_q];
  assign accept    = rst_n && (state_q == BURST) && own_vld && can_wr;
  assign last_beat = (burst_cnt_q == BCW'(BURST_MAX - 1));

  always_comb begin
    req_ready          = '0;
    req_ready[owner_q] = accept;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    wr_en_d     = accept;
    data_d      = accept ? req_beat[owner_q] : data_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d     = BURST;
          owner_d     = winner;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (accept) burst_cnt_d = burst_cnt_q + BCW'(1);
        if ((accept && last_beat) || !own_vld) begin
          state_d  = IDLE;
          rr_ptr_d = IDW'(rr_next(32'(owner_q), NUM_REQ));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      data_q      <= '0;
      wr_en_dly_q <= 1'b0;
      ovf_cnt_q   <= '0;
      ack_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      wr_en_dly_q <= wr_en_q;
      if (wr_ack != wr_en_dly_q) ack_err_q <= 1'b1;
      if (overflow && (ovf_cnt_q != 8'hFF)) ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
  end

  assign wr_en       = wr_en_q;
  assign data_in     = data_q;
  assign grant_valid = (state_q == BURST);
  assign grant_id    = owner_q;
  assign ovf_cnt     = ovf_cnt_q;
  assign ack_err     = ack_err_q;

endmodule
